// File: rtl/seq_multiplier_if.sv
// Handshake bundle for the iterative signed multiplier: start/operands in,
// product/busy/done out.
interface seq_multiplier_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;

  modport master (output start, a, b, input  p, busy, done);
  modport slave  (input  start, a, b, output p, busy, done);
endinterface

// File: rtl/seq_multiplier.sv
// Iterative signed multiplier: sign-magnitude shift-add, one partial product
// per clock; done pulses W+1 cycles after start is accepted.
module seq_multiplier #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_multiplier_if.slave  bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic [2*W-1:0] p_q, p_d;
  logic           done_q, done_d;

  logic [W:0]     sum;
  logic [W-1:0]   a_mag, b_mag;

  // Magnitudes are unsigned W bits, so the most negative operand maps to 2^(W-1).
  assign a_mag = bus.a[W-1] ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = bus.b[W-1] ? (~bus.b + 1'b1) : bus.b;
  assign sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplier_q[0] ? mcand_q : {W{1'b0}})};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = bus.a[W-1] ^ bus.b[W-1];
          acc_d    = '0;
          cnt_d    = CW'(W);
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry of sum enters at the top; low product bits trickle down through acc.
        acc_d    = {sum, acc_q[W-1:1]};
        mplier_d = {acc_q[0], mplier_q[W-1:1]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        p_d     = neg_q ? (~acc_q + 1'b1) : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      done_q   <= done_d;
    end
  end

  assign bus.p    = p_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus queues expected products,
// a negedge monitor pops them on every done pulse.
module tb_seq_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.W(W)) bus ();

  seq_multiplier #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2*W-1:0] p;
    string          nm;
  } exp_t;

  exp_t expq[$];
  int   accq[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_done = -1;
  int   done_cnt = 0;
  bit   bb_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // Monitor: records accept cycles and checks every done pulse against the queue.
  initial begin
    bit   bprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0;
        last_done = -1;
        continue;
      end
      if (bus.busy && !bprev) accq.push_back(cyc);
      bprev = bus.busy;
      if (bus.done) begin
        done_cnt++;
        if (expq.size() == 0) chk("unexpected_done", expq.size(), 1);
        else begin
          e = expq.pop_front();
          chk(e.nm, bus.p, e.p);
          if (accq.size() > 0) chk({e.nm, "_lat"}, cyc - accq.pop_front(), W + 1);
          if (bb_mode && last_done >= 0) chk("period", cyc - last_done, W + 2);
          last_done = cyc;
        end
      end
    end
  end

  task automatic wait_drain(string nm);
    int t = 0;
    while (expq.size() > 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (expq.size() > 0) begin
      chk({"timeout_", nm}, expq.size(), 0);
      expq.delete();
      accq.delete();
    end
  endtask

  task automatic wait_busy(logic v, string nm);
    int t = 0;
    while (bus.busy !== v && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (bus.busy !== v) chk(nm, bus.busy, v);
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] e, string nm);
    exp_t x;
    x.p = e; x.nm = nm;
    expq.push_back(x);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain(nm);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'h07, 8'hFD, 16'hFFEB},
    '{8'h80, 8'h80, 16'h4000},
    '{8'h80, 8'h7F, 16'hC080},
    '{8'h00, 8'hFB, 16'h0000},
    '{8'hFF, 8'hFF, 16'h0001},
    '{8'h7F, 8'h7F, 16'h3F01},
    '{8'h01, 8'h80, 16'hFF80},
    '{8'hFD, 8'h05, 16'hFFF1},
    '{8'h80, 8'h01, 16'hFF80}
  };

  initial begin
    int              d0;
    exp_t            x;
    logic signed [W-1:0]   sa, sb;
    logic signed [2*W-1:0] pr;

    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #2;
    chk("rst_p",    bus.p,    0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("dir%0d", i));

    // start re-pulsed mid-CALC with different operands must be ignored
    d0 = done_cnt;
    x.p = 16'h0084; x.nm = "ignore_start";
    expq.push_back(x);
    bus.a = 8'h0C; bus.b = 8'h0B; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.a = 8'h55; bus.b = 8'h33; bus.start = 1'b1;
    chk("busy_calc", bus.busy, 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_pulse", bus.busy, 1);
    wait_drain("ignore_start");
    repeat (15) @(posedge clk);
    #1;
    chk("single_done", done_cnt - d0, 1);
    chk("p_hold", bus.p, 16'h0084);

    // async reset in the 4th CALC cycle abandons the op
    x.p = 16'h0143; x.nm = "abandoned";
    expq.push_back(x);
    bus.a = 8'h13; bus.b = 8'h11; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_p",    bus.p,    0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    expq.delete();
    accq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    do_op(8'hF6, 8'h0C, 16'hFF88, "post_reset");

    // back-to-back with start held high
    bb_mode = 1'b1;
    last_done = -1;
    bus.start = 1'b1;
    for (int i = 0; i < 9 + 200; i++) begin
      if (i < 9) begin
        bus.a = vecs[i].a; bus.b = vecs[i].b;
        x.p = vecs[i].p;
      end else begin
        bus.a = W'($urandom); bus.b = W'($urandom);
        sa = bus.a; sb = bus.b;
        pr = sa * sb;
        x.p = pr;
      end
      x.nm = $sformatf("bb%0d", i);
      expq.push_back(x);
      wait_busy(1'b0, "bb_idle_timeout");
      wait_busy(1'b1, "bb_accept_timeout");
    end
    bus.start = 1'b0;
    wait_drain("bb_tail");
    bb_mode = 1'b0;
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
